// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand/result bundle for the pipelined adder
interface pipelined_adder_if #(
   parameter int WIDTH = 37
);
   logic             valid_in;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             sub;
   logic             valid_out;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             overflow;

   modport master (
      output valid_in, a, b, c_in, sub,
      input  valid_out, sum, c_out, overflow
   );

   modport slave (
      input  valid_in, a, b, c_in, sub,
      output valid_out, sum, c_out, overflow
   );
endinterface

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - sliced, carry-registered add/subtract pipeline
module pipelined_adder #(
   parameter int WIDTH = 37,
   parameter int CHUNK = 8
) (
   input  logic               clock,
   input  logic               reset_n,
   pipelined_adder_if.slave   bus
);
   localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;
   localparam int LAST_W = WIDTH - (STAGES - 1) * CHUNK;

   // Inputs seen by stage k: stage 0 takes the bus, later stages take the
   // registers of the stage below. Operands travel whole so each stage only
   // picks out its own slice; consumed bits are dead after that stage.
   logic             stg_v [0:STAGES-1];
   logic             stg_c [0:STAGES-1];
   logic [WIDTH-1:0] stg_a [0:STAGES-1];
   logic [WIDTH-1:0] stg_b [0:STAGES-1];
   logic [WIDTH-1:0] stg_s [0:STAGES-1];

   // Register outputs of stage k
   logic             pipe_v [0:STAGES-1];
   logic             pipe_c [0:STAGES-1];
   logic [WIDTH-1:0] pipe_a [0:STAGES-1];
   logic [WIDTH-1:0] pipe_b [0:STAGES-1];
   logic [WIDTH-1:0] pipe_s [0:STAGES-1];

   // Subtract is a + ~b + 1: invert b once at entry and force the carry-in.
   assign stg_v[0] = bus.valid_in;
   assign stg_c[0] = bus.sub ? 1'b1 : bus.c_in;
   assign stg_a[0] = bus.a;
   assign stg_b[0] = bus.sub ? ~bus.b : bus.b;
   assign stg_s[0] = '0;

   for (genvar k = 0; k < STAGES; k++) begin : gen_stage
      localparam int LO = k * CHUNK;
      localparam int SW = (k == STAGES - 1) ? LAST_W : CHUNK;

      logic [SW:0]      slice_d;
      logic [WIDTH-1:0] sum_d;
      logic             v_q;
      logic             c_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] s_q;

      if (k > 0) begin : gen_link
         assign stg_v[k] = pipe_v[k-1];
         assign stg_c[k] = pipe_c[k-1];
         assign stg_a[k] = pipe_a[k-1];
         assign stg_b[k] = pipe_b[k-1];
         assign stg_s[k] = pipe_s[k-1];
      end

      // One slice-wide ripple with the carry from the stage below; the top
      // bit of slice_d is the carry handed to the next stage.
      assign slice_d = {1'b0, stg_a[k][LO +: SW]}
                     + {1'b0, stg_b[k][LO +: SW]}
                     + {{SW{1'b0}}, stg_c[k]};

      // Merge this slice into the partial result carried alongside the op
      always_comb begin
         sum_d            = stg_s[k];
         sum_d[LO +: SW]  = slice_d[SW-1:0];
      end

      // Valid always advances; data only loads behind a valid op so the
      // final stage naturally holds the last result during bubbles.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
         end else begin
            v_q <= stg_v[k];
            if (stg_v[k]) begin
               c_q <= slice_d[SW];
               a_q <= stg_a[k];
               b_q <= stg_b[k];
               s_q <= sum_d;
            end
         end
      end

      assign pipe_v[k] = v_q;
      assign pipe_c[k] = c_q;
      assign pipe_a[k] = a_q;
      assign pipe_b[k] = b_q;
      assign pipe_s[k] = s_q;

      if (k == STAGES - 1) begin : gen_ovf
         logic ovf_d;
         logic ovf_q;

         // Signed overflow: operands agree in sign but the result does not
         assign ovf_d = (stg_a[k][WIDTH-1] == stg_b[k][WIDTH-1])
                     && (slice_d[SW-1] != stg_a[k][WIDTH-1]);

         // Overflow flag registered alongside the final slice
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               ovf_q <= 1'b0;
            end else if (stg_v[k]) begin
               ovf_q <= ovf_d;
            end
         end

         assign bus.overflow = ovf_q;
      end
   end

   assign bus.valid_out = pipe_v[STAGES-1];
   assign bus.sum       = pipe_s[STAGES-1];
   assign bus.c_out     = pipe_c[STAGES-1];
endmodule
